// File: rtl/writeback_regfile.sv
// Writeback stage with a 32x32 register file, optional same-cycle write-to-read
// forwarding and a wrapping count of committed writes.
module writeback_regfile #(
   parameter int BYPASS = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      ALU_i,
   input  logic [31:0]      data_i,
   input  logic [4:0]       RD_i,
   input  logic             MemtoReg_i,
   input  logic             RegWrite_i,
   input  logic [4:0]       RS1addr_i,
   input  logic [4:0]       RS2addr_i,
   output logic [31:0]      RS1data_o,
   output logic [31:0]      RS2data_o,
   output logic [31:0]      WBdata_o,
   output logic             WBvalid_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   logic [31:0]      regs_q [32];
   logic [31:0]      regs_d [32];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [31:0]      wb_data;
   logic             wb_valid;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;

   always_comb begin
      wb_data  = MemtoReg_i ? data_i : ALU_i;
      wb_valid = RegWrite_i && (RD_i != 5'd0);
   end

   // x0 is pinned to zero so a stray write can never make it visible.
   always_comb begin
      regs_d    = regs_q;
      regs_d[0] = '0;
      cnt_d     = cnt_q;
      if (wb_valid) begin
         regs_d[RD_i] = wb_data;
         cnt_d        = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   // Forwarding is masked during reset so a pending write cannot leak out.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (!rst_i && (RS1addr_i != 5'd0)) begin
         if ((BYPASS != 0) && wb_valid && (RS1addr_i == RD_i)) begin
            rs1_data = wb_data;
         end else begin
            rs1_data = regs_q[RS1addr_i];
         end
      end
      if (!rst_i && (RS2addr_i != 5'd0)) begin
         if ((BYPASS != 0) && wb_valid && (RS2addr_i == RD_i)) begin
            rs2_data = wb_data;
         end else begin
            rs2_data = regs_q[RS2addr_i];
         end
      end
   end

   assign RS1data_o    = rs1_data;
   assign RS2data_o    = rs2_data;
   assign WBdata_o     = wb_data;
   assign WBvalid_o    = wb_valid;
   assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench: a forwarding instance and a non-forwarding 4-bit-counter
// instance share stimulus and are compared against an array-based model.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] aluIn = '0;
   logic [31:0] dataIn = '0;
   logic [4:0]  rdIn = '0;
   logic        memToReg = 1'b0;
   logic        regWrite = 1'b0;
   logic [4:0]  rs1Addr = '0;
   logic [4:0]  rs2Addr = '0;

   logic [31:0] rs1A, rs2A, wbA;
   logic        validA;
   logic [31:0] cntA;
   logic [31:0] rs1B, rs2B, wbB;
   logic        validB;
   logic [3:0]  cntB;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model [32];
   int unsigned commits = 0;

   always #5 clk = ~clk;

   writeback_regfile #(.BYPASS(1), .CNT_W(32)) dutByp (
      .clk_i(clk), .rst_i(rst), .ALU_i(aluIn), .data_i(dataIn), .RD_i(rdIn),
      .MemtoReg_i(memToReg), .RegWrite_i(regWrite),
      .RS1addr_i(rs1Addr), .RS2addr_i(rs2Addr),
      .RS1data_o(rs1A), .RS2data_o(rs2A), .WBdata_o(wbA), .WBvalid_o(validA),
      .retire_cnt_o(cntA)
   );

   writeback_regfile #(.BYPASS(0), .CNT_W(4)) dutNoByp (
      .clk_i(clk), .rst_i(rst), .ALU_i(aluIn), .data_i(dataIn), .RD_i(rdIn),
      .MemtoReg_i(memToReg), .RegWrite_i(regWrite),
      .RS1addr_i(rs1Addr), .RS2addr_i(rs2Addr),
      .RS1data_o(rs1B), .RS2data_o(rs2B), .WBdata_o(wbB), .WBvalid_o(validB),
      .retire_cnt_o(cntB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] expWb();
      return memToReg ? dataIn : aluIn;
   endfunction

   function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
      if (rst) return '0;
      if (a == 5'd0) return '0;
      if (byp && regWrite && (rdIn != 5'd0) && (rdIn == a)) return expWb();
      return model[a];
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 32; i++) model[i] = '0;
      commits = 0;
   endtask

   task automatic checkCycle();
      logic [31:0] e;
      checkOutput("wbdataA", wbA, expWb());
      checkOutput("wbdataB", wbB, expWb());
      checkOutput("wbvalidA", {31'd0, validA}, {31'd0, regWrite && (rdIn != 5'd0)});
      checkOutput("wbvalidB", {31'd0, validB}, {31'd0, regWrite && (rdIn != 5'd0)});
      checkOutput("rs1A", rs1A, expRead(rs1Addr, 1'b1));
      checkOutput("rs2A", rs2A, expRead(rs2Addr, 1'b1));
      checkOutput("rs1B", rs1B, expRead(rs1Addr, 1'b0));
      checkOutput("rs2B", rs2B, expRead(rs2Addr, 1'b0));
      checkOutput("cntA", cntA, commits);
      e = commits % 16;
      checkOutput("cntB", {28'd0, cntB}, e);
   endtask

   task automatic applyStimulus(input logic r, input logic rw, input logic mr,
                                input logic [4:0] rd, input logic [31:0] alu,
                                input logic [31:0] data, input logic [4:0] a1,
                                input logic [4:0] a2);
      @(negedge clk);
      rst = r; regWrite = rw; memToReg = mr; rdIn = rd;
      aluIn = alu; dataIn = data; rs1Addr = a1; rs2Addr = a2;
      if (r) clearModel();
      #1;
      checkCycle();
      @(posedge clk);
      if (!rst && regWrite && (rdIn != 5'd0)) begin
         model[rdIn] = expWb();
         commits++;
      end
   endtask

   initial begin
      logic [4:0] rd, a1, a2;
      clearModel();

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 3, 31);
      #1;
      checkOutput("rst_cntA", cntA, 32'd0);

      // Write then read
      applyStimulus(0, 1, 0, 5, 32'h12345678, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
      checkOutput("wr_rd_rs1", rs1A, 32'h12345678);
      checkOutput("wr_rd_cnt", cntA, 32'd1);

      // Load path targeting x0
      applyStimulus(0, 1, 1, 0, 0, 32'hDEADBEEF, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_cnt", cntA, 32'd1);

      // Same-cycle bypass versus registered read
      applyStimulus(0, 1, 0, 7, 32'h0BADF00D, 0, 0, 0);
      applyStimulus(0, 1, 0, 7, 32'hA5A5A5A5, 0, 7, 7);
      applyStimulus(0, 0, 0, 0, 0, 0, 7, 7);
      checkOutput("byp_after", rs1B, 32'hA5A5A5A5);

      // Undefined data while not writing
      applyStimulus(0, 0, 0, 7, 'x, 'x, 7, 5);

      // Fill x1..x31, then reset asynchronously with a write pending
      for (int i = 1; i < 32; i++) begin
         applyStimulus(0, 1, 0, 5'(i), 32'(i) * 32'h11, 0, 5'(i - 1), 5'(i));
      end
      @(negedge clk);
      rst = 1'b0; regWrite = 1'b1; memToReg = 1'b0; rdIn = 5'd9;
      aluIn = 32'hFFFF0000; rs1Addr = 5'd9; rs2Addr = 5'd31;
      #1;
      checkOutput("pre_rst_rs2", rs2A, 32'd31 * 32'h11);
      #1;
      rst = 1'b1;
      clearModel();
      #1;
      checkCycle();
      for (int i = 0; i < 32; i++) begin
         rs1Addr = 5'(i); rs2Addr = 5'(31 - i);
         #1;
         checkOutput("rst_rs1", rs1A, 32'd0);
         checkOutput("rst_rs2B", rs2B, 32'd0);
      end
      @(posedge clk);
      #1;
      checkOutput("rst_hold_cnt", cntA, 32'd0);

      // First commit right after reset release, then counter wrap
      applyStimulus(0, 1, 0, 3, 32'h33, 0, 3, 0);
      #1;
      checkOutput("first_commit", cntA, 32'd1);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 1, 0, 5'(i + 1), 32'(i), 0, 0, 0);
      end
      #1;
      checkOutput("wrap16", {28'd0, cntB}, 32'd0);
      applyStimulus(0, 1, 0, 2, 32'h2, 0, 0, 0);
      #1;
      checkOutput("wrap17", {28'd0, cntB}, 32'd1);

      // Random regression
      for (int n = 0; n < 10000; n++) begin
         rd = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 499) == 0), 1'($urandom), 1'($urandom),
                       rd, $urandom, $urandom, a1, a2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
Parameters:
REQ-001 The block SHALL provide parameter BYPASS, default 1: 1 means same-cycle write-to-read forwarding; 0 means reads return the stored value only.
REQ-002 The block SHALL provide parameter CNT_W, default 32: width of the retire counter.

Ports:
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 ALU_i  input  32  ALU result from the MEM/WB pipeline register.
REQ-006 data_i  input  32  load data from the MEM/WB pipeline register.
REQ-007 RD_i  input  5  destination register index.
REQ-008 MemtoReg_i  input  1  1 selects data_i as the writeback value; 0 selects ALU_i.
REQ-009 RegWrite_i  input  1  writeback enable.
REQ-010 RS1addr_i, RS2addr_i  input  5 each  read-port indices from decode.
REQ-011 RS1data_o, RS2data_o  output  32 each  read-port data.
REQ-012 WBdata_o  output  32  selected writeback value, for EX-stage forwarding.
REQ-013 WBvalid_o  output  1  asserted when a write actually commits this cycle.
REQ-014 retire_cnt_o  output  CNT_W  count of committed writes.

Function
REQ-015 WBdata_o SHALL be combinational: data_i when MemtoReg_i=1, else ALU_i.
REQ-016 The register file SHALL hold 32 entries of 32 bits; x0 SHALL always read 0 and SHALL never be written.
REQ-017 A write SHALL commit at the rising edge when RegWrite_i=1 and RD_i!=0; it writes WBdata_o into entry RD_i.
REQ-018 WBvalid_o SHALL be combinational and equal RegWrite_i AND (RD_i!=0).
REQ-019 Read ports SHALL be combinational; zero read latency.
REQ-020 With BYPASS=1, when WBvalid_o=1 and RSnaddr_i==RD_i, RSn data_o SHALL equal WBdata_o in the same cycle.
REQ-021 With BYPASS=0, the read in REQ-020 SHALL return the old stored value; the new value SHALL be visible from the cycle after the commit edge.
REQ-022 Both read ports SHALL be independent; both may address the same entry, including RD_i, simultaneously.
REQ-023 retire_cnt_o SHALL increment by 1 at each edge on which a write commits.
REQ-024 retire_cnt_o SHALL wrap modulo 2^CNT_W: all-ones followed by a commit gives 0.
REQ-025 RegWrite_i=1 with RD_i=0 SHALL change no register and SHALL NOT increment retire_cnt_o.
REQ-026 X or undefined ALU_i or data_i values SHALL NOT affect state when RegWrite_i=0.

Reset
REQ-027 Asserting rst_i SHALL immediately, without waiting for a clock edge, clear all 32 entries and retire_cnt_o to 0.
REQ-028 While rst_i=1, no write SHALL commit and retire_cnt_o SHALL hold 0.
REQ-029 While rst_i=1, read outputs SHALL return 0 from storage; with BYPASS=1, the REQ-020 forwarding path SHALL also be suppressed.
REQ-030 rst_i asserted in the middle of a write cycle SHALL discard that write.
REQ-031 The first commit SHALL be possible on the first rising edge after rst_i deasserts.

Verification
REQ-032 Write then read: RegWrite_i=1, RD_i=5, MemtoReg_i=0, ALU_i=0x12345678, one edge; then RS1addr_i=5 -> RS1data_o=0x12345678, retire_cnt_o=1.
REQ-033 Load path and x0: MemtoReg_i=1, data_i=0xDEADBEEF, RD_i=0, RegWrite_i=1 -> WBdata_o=0xDEADBEEF, WBvalid_o=0; after the edge RS2addr_i=0 reads 0 and retire_cnt_o is unchanged.
REQ-034 Same-cycle bypass with BYPASS=1: RD_i=7, ALU_i=0xA5A5A5A5, RS1addr_i=RS2addr_i=7 before the edge -> both outputs read 0xA5A5A5A5. With BYPASS=0 -> both read the old value until after the edge.
REQ-035 Async reset mid-operation: fill x1..x31 with index*0x11; assert rst_i between edges -> all reads 0 and retire_cnt_o=0 before the next edge; a write presented during reset is discarded.
REQ-036 Counter wrap: CNT_W=4, 16 commits -> retire_cnt_o=0; 17 commits -> 1.
REQ-037 Random regression: random RegWrite_i, RD_i, MemtoReg_i and data checked against a reference model every cycle for 10,000 cycles.
